// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module   : wb_arbiter_pkg
// Purpose  : Shared widths, unit indices and queue entry type for wb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   localparam logic [1:0] UNIT_X = 2'd0;
   localparam logic [1:0] UNIT_Y = 2'd1;
   localparam logic [1:0] UNIT_M = 2'd2;

   typedef struct packed {
      logic [REG_W-1:0]  regdest;
      logic [DATA_W-1:0] wbvalue;
   } wb_entry_t;

   // Round-robin successor: X -> Y -> M -> X.
   function automatic logic [1:0] next_unit(input logic [1:0] unit);
      return (unit == UNIT_M) ? UNIT_X : unit + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_queue.sv
// ============================================================================
// Module   : wb_queue
// Purpose  : DEPTH-entry FIFO of writeback entries; push into a full queue is
//            dropped unless the same cycle also pops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_queue
   import wb_arbiter_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  wb_entry_t        i_data,
   output wb_entry_t        o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push_ok;
   logic w_pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Queues X/Y/M execute results and grants one per cycle,
//            round-robin, onto the register-file write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_W-1:0]  x_wb_regdest,
   input  logic              x_wb_writereg,
   input  logic [DATA_W-1:0] x_wb_wbvalue,
   input  logic [REG_W-1:0]  y_wb_regdest,
   input  logic              y_wb_writereg,
   input  logic [DATA_W-1:0] y_wb_wbvalue,
   input  logic [REG_W-1:0]  m_wb_regdest,
   input  logic              m_wb_writereg,
   input  logic [DATA_W-1:0] m_wb_wbvalue,
   output logic [REG_W-1:0]  ex_wb_regdest,
   output logic              ex_wb_writereg,
   output logic [DATA_W-1:0] ex_wb_wbvalue,
   output logic              wb_is_stall,
   output logic              wb_overflow
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [1:0]       r_rr;
   logic [2:0]       w_wr;
   logic [2:0]       w_push;
   logic [2:0]       w_pop;
   logic [2:0]       w_acc;
   logic [2:0]       w_full;
   logic [2:0]       w_empty;
   logic [2:0]       w_near_full;
   logic [2:0]       w_drop;
   wb_entry_t        w_in   [3];
   wb_entry_t        w_head [3];
   logic [CNT_W-1:0] w_cnt  [3];
   logic [CNT_W-1:0] w_nxt  [3];
   logic             w_gnt_vld;
   logic [1:0]       w_gnt_idx;
   logic [1:0]       w_cand;
   wb_entry_t        w_gnt_entry;

   assign w_wr          = {m_wb_writereg, y_wb_writereg, x_wb_writereg};
   assign w_in[UNIT_X]  = '{regdest: x_wb_regdest, wbvalue: x_wb_wbvalue};
   assign w_in[UNIT_Y]  = '{regdest: y_wb_regdest, wbvalue: y_wb_wbvalue};
   assign w_in[UNIT_M]  = '{regdest: m_wb_regdest, wbvalue: m_wb_wbvalue};

   generate
      for (genvar g = 0; g < 3; g++) begin : g_queue
         // A write to r0 is architecturally a no-op, so it never occupies a slot.
         assign w_push[g]      = w_wr[g] && (w_in[g].regdest != '0);
         assign w_acc[g]       = w_push[g] && (!w_full[g] || w_pop[g]);
         assign w_drop[g]      = w_push[g] && w_full[g] && !w_pop[g];
         assign w_nxt[g]       = w_cnt[g] + CNT_W'(w_acc[g]) - CNT_W'(w_pop[g]);
         assign w_near_full[g] = (w_nxt[g] >= CNT_W'(DEPTH - 1));

         wb_queue #(.DEPTH(DEPTH)) u_queue (
            .clock   (clock),
            .reset   (reset),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  (w_in[g]),
            .o_data  (w_head[g]),
            .o_count (w_cnt[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
         );
      end
   endgenerate

   // First non-empty queue starting at the rr pointer, using pre-edge state.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = r_rr;
      w_cand    = r_rr;
      for (int k = 0; k < 3; k++) begin
         if (!w_gnt_vld && !w_empty[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end
         w_cand = next_unit(w_cand);
      end
   end

   assign w_pop       = w_gnt_vld ? (3'b001 << w_gnt_idx) : 3'b000;
   assign w_gnt_entry = w_head[w_gnt_idx];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr           <= UNIT_X;
         ex_wb_writereg <= 1'b0;
         ex_wb_regdest  <= '0;
         ex_wb_wbvalue  <= '0;
         wb_is_stall    <= 1'b0;
         wb_overflow    <= 1'b0;
      end else begin
         if (w_gnt_vld) begin
            r_rr <= next_unit(w_gnt_idx);
         end
         ex_wb_writereg <= w_gnt_vld;
         ex_wb_regdest  <= w_gnt_vld ? w_gnt_entry.regdest : '0;
         ex_wb_wbvalue  <= w_gnt_vld ? w_gnt_entry.wbvalue : '0;
         wb_is_stall    <= |w_near_full;
         wb_overflow    <= wb_overflow | (|w_drop);
      end
   end

endmodule

`default_nettype wire
